// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, load widths, instruction formats.
package decode_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} instr_fmt_e;

  // Unknown opcodes fall back to FmtR so they carry a zero immediate.
  function automatic instr_fmt_e fmt_of(input logic [6:0] opcode);
    instr_fmt_e fmt;
    case (opcode)
      OpLoad, OpImm, OpJalr, OpSystem: fmt = FmtI;
      OpStore:                         fmt = FmtS;
      OpBranch:                        fmt = FmtB;
      OpLui, OpAuipc:                  fmt = FmtU;
      OpJal:                           fmt = FmtJ;
      default:                         fmt = FmtR;
    endcase
    return fmt;
  endfunction

  function automatic logic rs1_used(input logic [6:0] opcode);
    return !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
  endfunction

  function automatic logic rs2_used(input logic [6:0] opcode);
    return (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator, sign-extended from bit 31 to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate according to the instruction format.
  always_comb begin
    imm32 = '0;
    case (fmt_of(instr_i[6:0]))
      FmtI: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FmtS: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FmtB: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      FmtU: imm32 = {instr_i[31:12], 12'b0};
      FmtJ: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN by replicating the sign bit.
  always_comb begin
    imm_o       = '0;
    imm_o[31:0] = imm32;
    for (int b = 32; b < XLEN; b++) begin
      imm_o[b] = imm32[31];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, register file read with write-back
// forwarding, load-use scoreboard and a single-entry output register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [2:0]      wb_funct3,
  input  logic            wb_is_load,
  input  logic [XLEN-1:0] wb_data
);

  localparam int unsigned IdxW     = $clog2(NREG);
  localparam bit          BypassEn = (BYPASS != 0);

  logic [6:0]      opcode;
  logic [IdxW-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] wb_ext;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            hazard, accept;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic            out_valid_q, out_valid_d;
  logic [6:0]      out_opcode_q, out_opcode_d;
  logic [2:0]      out_funct3_q, out_funct3_d;
  logic [6:0]      out_funct7_q, out_funct7_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_rs1_q, out_rs1_d;
  logic [XLEN-1:0] out_rs2_q, out_rs2_d;

  // Index bits above log2(NREG) are deliberately dropped.
  assign opcode  = in_instr[6:0];
  assign rs1_idx = in_instr[15 +: IdxW];
  assign rs2_idx = in_instr[20 +: IdxW];
  assign rd_idx  = in_instr[7 +: IdxW];
  assign wb_idx  = wb_rd[IdxW-1:0];

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm)
  );

  // Size/sign the write-back data by load width; non-loads write full width.
  always_comb begin
    wb_ext = wb_data;
    if (wb_is_load) begin
      case (wb_funct3)
        F3Lb:    for (int b = 8; b < XLEN; b++) wb_ext[b] = wb_data[7];
        F3Lh:    for (int b = 16; b < XLEN; b++) wb_ext[b] = wb_data[15];
        F3Lw:    for (int b = 32; b < XLEN; b++) wb_ext[b] = wb_data[31];
        F3Lbu:   for (int b = 8; b < XLEN; b++) wb_ext[b] = 1'b0;
        F3Lhu:   for (int b = 16; b < XLEN; b++) wb_ext[b] = 1'b0;
        default: wb_ext = wb_data;
      endcase
    end
  end

  // Operand read: x0 is hardwired, same-cycle write-back wins over the array.
  always_comb begin
    rs1_data = regs_q[rs1_idx];
    rs2_data = regs_q[rs2_idx];
    if (BypassEn && wb_valid && (wb_idx == rs1_idx)) rs1_data = wb_ext;
    if (BypassEn && wb_valid && (wb_idx == rs2_idx)) rs2_data = wb_ext;
    if (rs1_idx == '0) rs1_data = '0;
    if (rs2_idx == '0) rs2_data = '0;
  end

  // Load-use hazard; a load write-back arriving now resolves it when bypassing.
  always_comb begin
    logic rs1_wait, rs2_wait;
    rs1_wait = rs1_used(opcode) && busy_q[rs1_idx] &&
               !(BypassEn && wb_valid && wb_is_load && (wb_idx == rs1_idx));
    rs2_wait = rs2_used(opcode) && busy_q[rs2_idx] &&
               !(BypassEn && wb_valid && wb_is_load && (wb_idx == rs2_idx));
    hazard   = rs1_wait || rs2_wait;
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file and scoreboard next state; a new load's set beats a clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_valid && (wb_idx != '0)) regs_d[wb_idx] = wb_ext;
    if (wb_valid && wb_is_load) busy_d[wb_idx] = 1'b0;
    if (accept && (opcode == OpLoad) && (rd_idx != '0)) busy_d[rd_idx] = 1'b1;
  end

  // Output bundle: load on accept, otherwise hold; valid drops only on drain.
  always_comb begin
    out_opcode_d = out_opcode_q;
    out_funct3_d = out_funct3_q;
    out_funct7_d = out_funct7_q;
    out_rd_d     = out_rd_q;
    out_imm_d    = out_imm_q;
    out_rs1_d    = out_rs1_q;
    out_rs2_d    = out_rs2_q;
    out_valid_d  = out_valid_q;
    if (accept) begin
      out_opcode_d = opcode;
      out_funct3_d = in_instr[14:12];
      out_funct7_d = in_instr[31:25];
      out_rd_d     = in_instr[11:7];
      out_imm_d    = imm;
      out_rs1_d    = rs1_data;
      out_rs2_d    = rs2_data;
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_funct3_q <= '0;
      out_funct7_q <= '0;
      out_rd_q     <= '0;
      out_imm_q    <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_funct3_q <= out_funct3_d;
      out_funct7_q <= out_funct7_d;
      out_rd_q     <= out_rd_d;
      out_imm_q    <= out_imm_d;
      out_rs1_q    <= out_rs1_d;
      out_rs2_q    <= out_rs2_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_opcode   = out_opcode_q;
  assign out_funct3   = out_funct3_q;
  assign out_funct7   = out_funct7_q;
  assign out_rd       = out_rd_q;
  assign out_imm      = out_imm_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, NREG=32, BYPASS=1).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_rs1_data, out_rs2_data;
  logic        wb_valid, wb_is_load;
  logic [4:0]  wb_rd;
  logic [2:0]  wb_funct3;
  logic [31:0] wb_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN   (32),
    .NREG   (32),
    .BYPASS (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_funct3    (wb_funct3),
    .wb_is_load   (wb_is_load),
    .wb_data      (wb_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one instruction for a single edge; it must be accepted.
  task automatic issue(input logic [31:0] ins, input logic ordy);
    @(negedge clk);
    in_instr  = ins;
    in_valid  = 1'b1;
    out_ready = ordy;
    #1 chk("issue_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [2:0] f3, input logic ld,
                    input logic [31:0] d);
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = rd; wb_funct3 = f3; wb_is_load = ld; wb_data = d;
    @(posedge clk);
    #1 wb_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd1,  32'h00000005}; // addi x1,x0,5
    vecs[1] = '{32'hFFF00393, 7'h13, 3'd0, 7'h7F, 5'd7,  32'hFFFFFFFF}; // addi x7,x0,-1
    vecs[2] = '{32'hFE20AE23, 7'h23, 3'd2, 7'h7F, 5'd28, 32'hFFFFFFFC}; // sw x2,-4(x1)
    vecs[3] = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd5,  32'h12345000}; // lui x5
    vecs[4] = '{32'hFE208CE3, 7'h63, 3'd0, 7'h7F, 5'd25, 32'hFFFFFFF8}; // beq -8
    vecs[5] = '{32'h001000EF, 7'h6F, 3'd0, 7'h00, 5'd1,  32'h00000800}; // jal +2048
    vecs[6] = '{32'h00128333, 7'h33, 3'd0, 7'h00, 5'd6,  32'h00000000}; // add x6,x5,x1
    vecs[7] = '{32'hFFDFF06F, 7'h6F, 3'd7, 7'h7F, 5'd0,  32'hFFFFFFFC}; // jal x0,-4
    vecs[8] = '{32'h80000517, 7'h17, 3'd0, 7'h40, 5'd10, 32'h80000000}; // auipc

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_funct3 = '0; wb_is_load = 1'b0; wb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bundle", {out_opcode, out_funct3, out_funct7, out_rd, out_imm}, 0);

    // Decode table; registers still all zero so operands read as 0.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].instr, 1'b1);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_fields", i), {out_opcode, out_funct3, out_funct7, out_rd, out_imm},
          {vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].imm});
      chk($sformatf("vec%0d_rs1", i), out_rs1_data, 0);
    end
    drain();

    // Write-back extension.
    wb(5'd2, 3'b000, 1'b1, 32'h00000080);
    wb(5'd3, 3'b100, 1'b1, 32'h00000080);
    wb(5'd4, 3'b001, 1'b1, 32'h00008001);
    wb(5'd7, 3'b000, 1'b0, 32'hCAFEBABE);
    issue(32'h00310033, 1'b1);                 // add x0,x2,x3
    chk("lb_x2", out_rs1_data, 32'hFFFFFF80);
    chk("lbu_x3", out_rs2_data, 32'h00000080);
    issue(32'h00720033, 1'b1);                 // add x0,x4,x7
    chk("lh_x4", out_rs1_data, 32'hFFFF8001);
    chk("nonload_x7", out_rs2_data, 32'hCAFEBABE);
    wb(5'd2, 3'b101, 1'b1, 32'hFFFF8001);
    issue(32'h00010033, 1'b1);                 // add x0,x2,x0
    chk("lhu_x2", out_rs1_data, 32'h00008001);

    // Load-use stall released by a bypassed write-back.
    issue(32'h00002283, 1'b1);                 // lw x5,0(x0)
    @(negedge clk);
    in_instr = 32'h00128333; in_valid = 1'b1;  // add x6,x5,x1
    for (int c = 0; c < 3; c++) begin
      #1 chk("hazard_stall", in_ready, 0);
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_funct3 = 3'b010; wb_is_load = 1'b1; wb_data = 32'h1234;
    #1 chk("hazard_bypass_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; wb_valid = 1'b0;
    chk("bypass_valid", out_valid, 1);
    chk("bypass_rd", out_rd, 6);
    chk("bypass_rs1", out_rs1_data, 32'h1234);
    issue(32'h00028033, 1'b1);                 // add x0,x5,x0
    chk("x5_written", out_rs1_data, 32'h1234);

    // New load accepted while the old one writes back: busy must stay set.
    @(negedge clk);
    in_instr = 32'h00002283; in_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_funct3 = 3'b010; wb_is_load = 1'b1; wb_data = 32'h1234;
    @(posedge clk);
    #1 in_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    in_instr = 32'h00128333;
    #1 chk("set_wins", in_ready, 0);
    wb(5'd5, 3'b010, 1'b1, 32'h1234);
    drain();

    // Back-pressure holds the bundle, then drain plus accept keeps valid.
    issue(32'h00500093, 1'b0);
    @(negedge clk);
    in_instr = 32'hFFF00393; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1 chk("stall_hold", {out_valid, out_rd, out_imm}, {1'b1, 5'd1, 32'd5});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("unstall_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("unstall_next", {out_valid, out_rd, out_imm}, {1'b1, 5'd7, 32'hFFFFFFFF});
    drain();

    // x0 writes are discarded, including on the bypass path.
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_funct3 = 3'b000; wb_is_load = 1'b0; wb_data = 32'hDEAD;
    in_instr = 32'h00000033; in_valid = 1'b1;
    @(posedge clk);
    #1 wb_valid = 1'b0; in_valid = 1'b0;
    chk("x0_bypass", {out_rs1_data, out_rs2_data}, 0);
    issue(32'h00000033, 1'b1);
    chk("x0_read", {out_rs1_data, out_rs2_data}, 0);
    drain();

    // Reset in the middle of a load-use stall with a held bundle.
    issue(32'h00002403, 1'b0);                 // lw x8,0(x0)
    @(negedge clk);
    in_instr = 32'h005404B3; in_valid = 1'b1;  // add x9,x8,x5
    #1 chk("pre_reset_stall", in_ready, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_valid", out_valid, 0);
    chk("async_reset_rd", out_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_reset_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("post_reset_accept", {out_valid, out_rd}, {1'b1, 5'd9});
    chk("post_reset_regs", {out_rs1_data, out_rs2_data}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath and register width; SHALL accept 32 or 64.
REQ-002 Parameter NREG, 32, architectural register count; SHALL accept 16 or 32; rs/rd index bits above log2(NREG) ignored.
REQ-003 Parameter BYPASS, 1, 1 = same-cycle write-back forwarding into read data; 0 = none.
REQ-004 Design SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  in_instr holds a valid instruction.
REQ-008 in_ready  out  1  stage accepts in_instr this cycle.
REQ-009 in_instr  in  32  RV32 instruction word.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  downstream accepts bundle.
REQ-012 out_opcode/out_funct3/out_funct7/out_rd  out  7/3/7/5  decoded fields.
REQ-013 out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J).
REQ-014 out_rs1_data, out_rs2_data  out  XLEN  operand values.
REQ-015 wb_valid/wb_rd/wb_funct3/wb_is_load/wb_data  in  1/5/3/1/XLEN  register write-back port.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; in_ready = (!out_valid || out_ready) && !hazard.
REQ-017 On accept, output register SHALL load all fields, immediate and operands next edge; latency exactly 1 cycle.
REQ-018 Output bundle SHALL hold stable while out_valid && !out_ready.
REQ-019 out_valid SHALL clear on out_ready with no accept in the same cycle; accept plus drain SHALL keep out_valid = 1.
REQ-020 rs1 SHALL count as used for all opcodes except LUI (0110111), AUIPC (0010111), JAL (1101111); rs2 used only for R (0110011), S (0100011), B (1100011).
REQ-021 Scoreboard: one busy bit per register; accepting a load (opcode 0000011) with rd != 0 SHALL set busy[rd].
REQ-022 wb_valid && wb_is_load SHALL clear busy[wb_rd]; same-cycle set and clear of one index: set wins.
REQ-023 hazard SHALL be 1 when a used rs index is busy, unless BYPASS = 1 and that load's write-back arrives this cycle.
REQ-024 Write-back extension by wb_funct3 when wb_is_load: 000 lb sign-8, 001 lh sign-16, 010 lw sign-32, 100 lbu zero-8, 101 lhu zero-16, else full width; non-load writes full width.
REQ-025 wb_valid SHALL write extended data on the next edge; writes to x0 ignored; x0 reads SHALL return 0.
REQ-026 With BYPASS = 1, a read of index == wb_rd (nonzero) during wb_valid SHALL return extended wb_data.
REQ-027 Immediates SHALL be sign-extended from bit 31 to XLEN; R-type out_imm = 0.

Reset
REQ-028 Reset SHALL asynchronously clear all registers, scoreboard, out_valid and every output bundle field to 0.
REQ-029 Reset mid-operation SHALL discard held bundle and pending loads; first accept possible on first edge after deassertion.

Structure
REQ-030 Shared package decode_pkg SHALL hold opcode constants, load funct3 codes and the instruction-format enum.
REQ-031 Immediate generation SHALL be sub-module imm_gen (combinational, XLEN-parametrised); scoreboard and regfile stay inline.

Verification
REQ-032 Reset, then addi x1,x0,5 (0x00500093) -> one cycle later out_valid=1, out_rd=1, out_imm=5, out_rs1_data=0.
REQ-033 wb lb x2, wb_data=0x80 -> x2 reads 0xFFFFFF80; lbu x3 0x80 -> 0x00000080; lh x4 0x8001 -> 0xFFFF8001.
REQ-034 Accept lw x5; next instr add x6,x5,x1 -> in_ready=0 until wb x5=0x1234; with BYPASS=1 accept that same cycle, out_rs1_data=0x1234.
REQ-035 out_ready=0 for 3 cycles with valid bundle -> bundle unchanged, in_ready=0; out_ready=1 -> drains, next accepted.
REQ-036 wb_valid to x0 with 0xDEAD -> x0 reads 0; reset asserted mid-stall -> out_valid=0, busy cleared, in_ready=1 after release.
